vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Sequencing controller for a multi-slot vending machine. It accumulates coin credit in Rs.5 units, arbitrates a product selection against per-slot stock counters, and drives the selected slot's dispense motor for a fixed pulse. It then returns change coin-by-coin through a handshake with the coin hopper. It sits between the coin acceptor / keypad front end and the motor and hopper drivers.

## Interface
- SLOTS, 4: number of product slots; `sel_slot`/`refill_slot` width is clog2(SLOTS).
- STOCK_W, 4: stock counter width per slot.
- PRICE, 3: product price in Rs.5 units (3 = Rs.15).
- CREDIT_MAX, 6: maximum held credit in Rs.5 units (6 = Rs.30).
- MOTOR_CYCLES, 8: motor pulse length in clocks; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- coin_valid  in  1  coin strobe, one cycle per coin.
- coin_val  in  2  01 = Rs.5, 10 = Rs.10; 00/11 are treated as an invalid coin.
- sel_valid  in  1  selection strobe.
- sel_slot  in  clog2(SLOTS)  selected slot.
- cancel  in  1  refund request.
- refill  in  1  stock load strobe.
- refill_slot  in  clog2(SLOTS)  slot to load.
- refill_cnt  in  STOCK_W  new stock value.
- motor_en  out  SLOTS  one-hot motor drive.
- hopper_req  out  1  change coin request.
- hopper_coin  out  2  coin requested: 01 = Rs.5, 10 = Rs.10.
- hopper_ack  in  1  hopper has paid the requested coin.
- coin_reject  out  1  one-cycle pulse: coin not accepted, returned mechanically.
- sold_out  out  1  one-cycle pulse: selected slot is empty.
- vend_done  out  1  one-cycle pulse at the end of a vend transaction.
- refund_done  out  1  one-cycle pulse at the end of a cancel transaction.
- busy  out  1  high in any state other than IDLE.
- credit  out  4  current credit, in Rs.5 units.

## Operation
- States: IDLE, DISPENSE, CHANGE, DONE. A `vended` flag records whether DONE was reached via DISPENSE.
- Reset (async, any state): state → IDLE.
  - credit, all stock counters, motor counter and `vended` → 0.
  - Every output → 0 immediately; the motor stops mid-pulse.
  - Credit held at reset is forfeited.
- IDLE, events in priority order, evaluated each cycle:
  - **refill**: stock[refill_slot] ← refill_cnt. A sel_valid or cancel in the same cycle is ignored.
  - **cancel**: go to CHANGE with `vended`=0. If credit=0 at that point, go directly to DONE instead.
  - **sel_valid with credit ≥ PRICE and stock[sel_slot] > 0**: stock decrements, credit ← credit − PRICE, `vended`=1, go to DISPENSE.
  - **sel_valid with stock[sel_slot] = 0**: pulse sold_out; credit is unchanged.
  - **sel_valid with credit < PRICE**: ignored.
  - The selection test uses credit *before* a same-cycle coin is added.
- Coin handling:
  - Coins are accepted only in IDLE, and only when the cancel branch is not taken that cycle.
  - An accepted coin adds 1 (Rs.5) or 2 (Rs.10) to credit, combined with any same-cycle PRICE deduction.
  - A coin is rejected, with a coin_reject pulse the next cycle, when:
    - it is invalid, or
    - the result would exceed CREDIT_MAX, or
    - the controller is not in IDLE, or
    - it arrives in the same cycle as a taken cancel.
- DISPENSE: motor_en[slot] is high for exactly MOTOR_CYCLES cycles, then the state goes to CHANGE (credit > 0) or DONE (credit = 0).
- CHANGE:
  - hopper_coin = 10 if credit ≥ 2, else 01. hopper_req is high with hopper_coin held stable.
  - On a cycle where hopper_req and hopper_ack are both high, credit decreases by 2 or 1 at that edge, and hopper_req drops for exactly one cycle.
  - When credit reaches 0, go to DONE.
  - hopper_ack while hopper_req is low is ignored.
- DONE: pulse vend_done if `vended`, else refund_done, then return to IDLE.
- Stock never underflows. credit never exceeds CREDIT_MAX and never goes negative.

## Timing
- All outputs are registered. Pulses last exactly one cycle.
- sel_valid sampled at edge k, vend accepted:
  - motor_en high in cycles k+1 … k+MOTOR_CYCLES.
  - First hopper_req or DONE in cycle k+MOTOR_CYCLES+1.
- A hopper_ack sampled at edge j gives the next hopper_req at cycle j+2 (one-cycle gap).
- DONE lasts one cycle, so the next IDLE-accepted input is at the following edge.
- sold_out and coin_reject are asserted the cycle after the causing strobe.
- busy is asserted from the cycle after leaving IDLE up to and including the DONE cycle.

## Test plan
- **Exact-price vend.** Refill slot 2 to 5, insert Rs.10 then Rs.5, select slot 2.
  - motor_en = 0100 for 8 cycles.
  - No hopper_req; vend_done pulse.
  - credit = 0, stock[2] = 4.
- **Vend with change.** Insert Rs.10 ×3 (credit 6), select slot 0 (stock 1), ack each request after 2 cycles.
  - Motor pulse of 8 cycles.
  - Hopper requests 10, then 01.
  - vend_done; credit = 0, stock[0] = 0.
- **Sold out and over-credit.** Select an empty slot with credit 3: sold_out pulse, credit stays 3. Then insert Rs.10 ×2: first accepted (credit 5), second rejected (coin_reject, credit 5).
- **Cancel.** Credit 5, cancel.
  - Hopper requests 10, 10, 01.
  - refund_done, with no motor activity.
  - A cancel with credit 0 pulses refund_done after 2 cycles.
- **Simultaneous events.**
  - refill + sel_valid in one cycle: only the refill takes effect.
  - coin_valid (Rs.5) + sel_valid with credit 3: vend proceeds, credit ends 1.
  - Coins during DISPENSE are rejected.
- **Reset mid-operation.** Assert rst in the 4th motor cycle.
  - motor_en = 0 asynchronously; all outputs 0; credit 0.
  - After release, select with 0 stock → sold_out.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// Vending sequencer: coin credit, slot stock arbitration, timed motor pulse and
// coin-by-coin change payout through a request/ack hopper handshake.
module vend_dispense_ctrl #(
   parameter int unsigned SLOTS        = 4,
   parameter int unsigned STOCK_W      = 4,
   parameter int unsigned PRICE        = 3,
   parameter int unsigned CREDIT_MAX   = 6,
   parameter int unsigned MOTOR_CYCLES = 8,
   localparam int unsigned SelW        = $clog2(SLOTS)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               coin_valid_i,
   input  logic [1:0]         coin_val_i,
   input  logic               sel_valid_i,
   input  logic [SelW-1:0]    sel_slot_i,
   input  logic               cancel_i,
   input  logic               refill_i,
   input  logic [SelW-1:0]    refill_slot_i,
   input  logic [STOCK_W-1:0] refill_cnt_i,
   output logic [SLOTS-1:0]   motor_en_o,
   output logic               hopper_req_o,
   output logic [1:0]         hopper_coin_o,
   input  logic               hopper_ack_i,
   output logic               coin_reject_o,
   output logic               sold_out_o,
   output logic               vend_done_o,
   output logic               refund_done_o,
   output logic               busy_o,
   output logic [3:0]         credit_o
);

   localparam int unsigned CntW   = $clog2(MOTOR_CYCLES) + 1;
   localparam logic [3:0]  PriceC = 4'(PRICE);
   localparam logic [3:0]  MaxC   = 4'(CREDIT_MAX);

   typedef enum logic [1:0] {StIdle, StDispense, StChange, StDone} state_e;

   state_e               state_q;
   logic [3:0]           credit_q;
   logic [STOCK_W-1:0]   stock_q [SLOTS];
   logic [CntW-1:0]      motor_cnt_q;
   logic                 vended_q;
   logic [SLOTS-1:0]     motor_en_q;
   logic                 hopper_req_q;
   logic [1:0]           hopper_coin_q;
   logic                 coin_reject_q;
   logic                 sold_out_q;
   logic                 vend_done_q;
   logic                 refund_done_q;
   logic                 busy_q;

   logic [3:0]           coin_add;
   logic                 in_idle;
   logic                 cancel_take;
   logic [STOCK_W-1:0]   sel_stock;
   logic                 vend_take;
   logic [3:0]           credit_base;
   logic                 coin_take;
   logic [3:0]           credit_idle;
   logic [1:0]           change_coin;
   logic [3:0]           change_amt;

   always_comb begin
      coin_add = 4'd0;
      case (coin_val_i)
         2'b01:   coin_add = 4'd1;
         2'b10:   coin_add = 4'd2;
         default: coin_add = 4'd0;
      endcase
      in_idle     = (state_q == StIdle);
      cancel_take = in_idle && !refill_i && cancel_i;
      sel_stock   = stock_q[sel_slot_i];
      vend_take   = in_idle && !refill_i && !cancel_i && sel_valid_i &&
                    (credit_q >= PriceC) && (sel_stock != '0);
      // Coin limit is judged against credit after any same-cycle price deduction.
      credit_base = vend_take ? credit_q - PriceC : credit_q;
      coin_take   = in_idle && coin_valid_i && (coin_add != 4'd0) && !cancel_take &&
                    (credit_base + coin_add <= MaxC);
      credit_idle = coin_take ? credit_base + coin_add : credit_base;
      change_coin = (credit_q >= 4'd2) ? 2'b10 : 2'b01;
      change_amt  = (hopper_coin_q == 2'b10) ? 4'd2 : 4'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         credit_q      <= 4'd0;
         stock_q       <= '{default: '0};
         motor_cnt_q   <= '0;
         vended_q      <= 1'b0;
         motor_en_q    <= '0;
         hopper_req_q  <= 1'b0;
         hopper_coin_q <= 2'b00;
         coin_reject_q <= 1'b0;
         sold_out_q    <= 1'b0;
         vend_done_q   <= 1'b0;
         refund_done_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         coin_reject_q <= coin_valid_i && !coin_take;
         sold_out_q    <= 1'b0;
         vend_done_q   <= 1'b0;
         refund_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               credit_q <= credit_idle;
               if (refill_i) begin
                  stock_q[refill_slot_i] <= refill_cnt_i;
               end else if (cancel_i) begin
                  vended_q <= 1'b0;
                  busy_q   <= 1'b1;
                  if (credit_q == 4'd0) begin
                     state_q <= StDone;
                  end else begin
                     state_q       <= StChange;
                     hopper_req_q  <= 1'b1;
                     hopper_coin_q <= change_coin;
                  end
               end else if (sel_valid_i) begin
                  if (sel_stock == '0) begin
                     sold_out_q <= 1'b1;
                  end else if (vend_take) begin
                     stock_q[sel_slot_i] <= sel_stock - STOCK_W'(1);
                     vended_q            <= 1'b1;
                     busy_q              <= 1'b1;
                     state_q             <= StDispense;
                     motor_en_q          <= SLOTS'(1) << sel_slot_i;
                     motor_cnt_q         <= CntW'(MOTOR_CYCLES - 1);
                  end
               end
            end
            StDispense: begin
               if (motor_cnt_q == '0) begin
                  motor_en_q <= '0;
                  if (credit_q != 4'd0) begin
                     state_q       <= StChange;
                     hopper_req_q  <= 1'b1;
                     hopper_coin_q <= change_coin;
                  end else begin
                     state_q <= StDone;
                  end
               end else begin
                  motor_cnt_q <= motor_cnt_q - CntW'(1);
               end
            end
            StChange: begin
               if (hopper_req_q) begin
                  if (hopper_ack_i) begin
                     credit_q     <= credit_q - change_amt;
                     hopper_req_q <= 1'b0;
                     if (credit_q == change_amt) begin
                        state_q       <= StDone;
                        hopper_coin_q <= 2'b00;
                     end
                  end
               end else begin
                  // One-cycle gap after each paid coin, then request the next one.
                  hopper_req_q  <= 1'b1;
                  hopper_coin_q <= change_coin;
               end
            end
            StDone: begin
               vend_done_q   <= vended_q;
               refund_done_q <= !vended_q;
               vended_q      <= 1'b0;
               busy_q        <= 1'b0;
               state_q       <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign motor_en_o    = motor_en_q;
   assign hopper_req_o  = hopper_req_q;
   assign hopper_coin_o = hopper_coin_q;
   assign coin_reject_o = coin_reject_q;
   assign sold_out_o    = sold_out_q;
   assign vend_done_o   = vend_done_q;
   assign refund_done_o = refund_done_q;
   assign busy_o        = busy_q;
   assign credit_o      = credit_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: directed scenarios followed by random
// transactions, all checked against a transaction-level credit/stock model.
module tb_vend_dispense_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_val = 2'b00;
   logic       sel_valid = 1'b0;
   logic [1:0] sel_slot = 2'd0;
   logic       cancel = 1'b0;
   logic       refill = 1'b0;
   logic [1:0] refill_slot = 2'd0;
   logic [3:0] refill_cnt = 4'd0;
   logic [3:0] motor_en;
   logic       hopper_req;
   logic [1:0] hopper_coin;
   logic       hopper_ack = 1'b0;
   logic       coin_reject;
   logic       sold_out;
   logic       vend_done;
   logic       refund_done;
   logic       busy;
   logic [3:0] credit;

   int n_assert = 0;
   int n_fail   = 0;
   int m_credit = 0;
   int m_stock [4] = '{0, 0, 0, 0};

   vend_dispense_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .coin_valid_i  (coin_valid),
      .coin_val_i    (coin_val),
      .sel_valid_i   (sel_valid),
      .sel_slot_i    (sel_slot),
      .cancel_i      (cancel),
      .refill_i      (refill),
      .refill_slot_i (refill_slot),
      .refill_cnt_i  (refill_cnt),
      .motor_en_o    (motor_en),
      .hopper_req_o  (hopper_req),
      .hopper_coin_o (hopper_coin),
      .hopper_ack_i  (hopper_ack),
      .coin_reject_o (coin_reject),
      .sold_out_o    (sold_out),
      .vend_done_o   (vend_done),
      .refund_done_o (refund_done),
      .busy_o        (busy),
      .credit_o      (credit)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no end of test, required $finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pays out remaining credit greedily (Rs.10 first) and checks the handshake.
   task automatic run_change(input int ack_dly);
      int c;
      int d;
      while (m_credit > 0) begin
         c = (m_credit >= 2) ? 2 : 1;
         check("hopper_req", 32'(hopper_req), 32'd1);
         check("hopper_coin", 32'(hopper_coin), 32'(c));
         check("motor_idle_chg", 32'(motor_en), 32'd0);
         d = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
         for (int i = 0; i < d; i++) begin
            step();
            check("hopper_hold", 32'(hopper_req), 32'd1);
            check("hopper_coin_hold", 32'(hopper_coin), 32'(c));
            check("credit_hold", 32'(credit), 32'(m_credit));
         end
         hopper_ack = 1'b1;
         step();
         hopper_ack = 1'b0;
         m_credit -= c;
         check("change_credit", 32'(credit), 32'(m_credit));
         check("hopper_gap", 32'(hopper_req), 32'd0);
         if (m_credit > 0) begin
            hopper_ack = 1'($urandom_range(0, 1));
            step();
            hopper_ack = 1'b0;
            check("gap_ack_ignored", 32'(credit), 32'(m_credit));
         end
      end
   endtask

   // One IDLE-cycle input set, then the whole resulting transaction back to IDLE.
   task automatic idle_op(input logic cv, input logic [1:0] cval, input logic sv,
                          input logic [1:0] sslot, input logic cn, input logic rf,
                          input logic [1:0] rslot, input logic [3:0] rcnt,
                          input int ack_dly, input int dsp_coins);
      int  add;
      int  base;
      bit  cancel_t;
      bit  sel_t;
      bit  vend;
      bit  sold;
      bit  acc;
      bit  dc;
      add      = (cval == 2'b01) ? 1 : (cval == 2'b10) ? 2 : 0;
      cancel_t = !rf && cn;
      sel_t    = !rf && !cn && sv;
      vend     = sel_t && (m_credit >= 3) && (m_stock[sslot] > 0);
      sold     = sel_t && (m_stock[sslot] == 0);
      base     = vend ? m_credit - 3 : m_credit;
      acc      = cv && (add > 0) && !cancel_t && (base + add <= 6);
      coin_valid = cv; coin_val = cval; sel_valid = sv; sel_slot = sslot;
      cancel = cn; refill = rf; refill_slot = rslot; refill_cnt = rcnt;
      step();
      coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0; refill = 1'b0;
      if (rf) m_stock[rslot] = int'(rcnt);
      if (vend) m_stock[sslot] -= 1;
      m_credit = acc ? base + add : base;
      check("sold_out", 32'(sold_out), 32'(sold));
      check("coin_reject", 32'(coin_reject), 32'(cv && !acc));
      check("credit", 32'(credit), 32'(m_credit));
      check("busy", 32'(busy), 32'(vend || cancel_t));
      if (vend) begin
         for (int i = 0; i < 8; i++) begin
            check("motor_en", 32'(motor_en), 32'(4'b0001 << sslot));
            check("hopper_req_dsp", 32'(hopper_req), 32'd0);
            dc = (dsp_coins == 1) || (dsp_coins == 2 && $urandom_range(0, 3) == 0);
            coin_valid = dc;
            coin_val   = 2'b01;
            step();
            coin_valid = 1'b0;
            check("dsp_coin_reject", 32'(coin_reject), 32'(dc));
            check("dsp_credit", 32'(credit), 32'(m_credit));
         end
         check("motor_off", 32'(motor_en), 32'd0);
      end
      if (vend || cancel_t) begin
         if (m_credit > 0) run_change(ack_dly);
         check("done_busy", 32'(busy), 32'd1);
         check("done_no_req", 32'(hopper_req), 32'd0);
         check("done_early", 32'(vend_done | refund_done), 32'd0);
         step();
         check("vend_done", 32'(vend_done), 32'(vend));
         check("refund_done", 32'(refund_done), 32'(cancel_t));
         check("busy_idle", 32'(busy), 32'd0);
         check("credit_end", 32'(credit), 32'd0);
      end
   endtask

   task automatic coin(input logic [1:0] v);
      idle_op(1'b1, v, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 2, 0);
   endtask

   initial begin
      step();
      step();
      check("rst_motor", 32'(motor_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_credit", 32'(credit), 32'd0);
      check("rst_req", 32'(hopper_req), 32'd0);
      rst = 1'b0;
      step();

      // Exact-price vend from slot 2.
      idle_op(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'd5, 2, 0);
      coin(2'b10);
      coin(2'b01);
      idle_op(1'b0, 2'b00, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0, 2, 0);

      // Vend with Rs.15 change from slot 0.
      idle_op(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 4'd1, 2, 0);
      coin(2'b10);
      coin(2'b10);
      coin(2'b10);
      idle_op(1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 2, 0);

      // Sold out, over-credit and invalid coins.
      coin(2'b10);
      coin(2'b01);
      idle_op(1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0, 2, 0);
      coin(2'b10);
      coin(2'b10);
      coin(2'b11);
      coin(2'b00);

      // Cancel with credit 5, then with credit 0; coin alongside cancel is rejected.
      idle_op(1'b1, 2'b01, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 1, 0);
      idle_op(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 1, 0);

      // Refill wins over select; coin plus select vends; coins rejected mid-dispense.
      coin(2'b10);
      coin(2'b01);
      idle_op(1'b0, 2'b00, 1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 4'd3, 2, 0);
      idle_op(1'b1, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 4'd0, 0, 1);

      // Random transactions.
      for (int n = 0; n < 250; n++) begin
         idle_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), -1, 2);
      end

      // Reset during the 4th motor cycle.
      idle_op(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3, 4'd2, 2, 0);
      while (m_credit < 3) coin(2'b01);
      sel_valid = 1'b1;
      sel_slot  = 2'd3;
      step();
      sel_valid = 1'b0;
      check("rst_pre_motor", 32'(motor_en), 32'b1000);
      step();
      step();
      step();
      check("rst_4th_motor", 32'(motor_en), 32'b1000);
      #2 rst = 1'b1;
      #1;
      check("async_motor", 32'(motor_en), 32'd0);
      check("async_busy", 32'(busy), 32'd0);
      check("async_credit", 32'(credit), 32'd0);
      check("async_pulses", 32'({hopper_req, hopper_coin, coin_reject, sold_out,
                                 vend_done, refund_done}), 32'd0);
      step();
      step();
      rst = 1'b0;
      m_credit = 0;
      for (int s = 0; s < 4; s++) m_stock[s] = 0;
      step();
      idle_op(1'b0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 4'd0, 2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
